// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
package cpu_ctrl_pkg;

  localparam int STATE_W         = 2;
  localparam int MEM_TIMEOUT_DEF = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_we;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
    logic memwb_bubble;
  } ctl_t;

  // Control patterns: frozen, free-running, load-use hold, branch squash, memory stall.
  localparam ctl_t CTL_OFF = 8'b0000_0000;
  localparam ctl_t CTL_ALL = 8'b1101_0110;
  localparam ctl_t CTL_LU  = 8'b0001_1110;
  localparam ctl_t CTL_BR  = 8'b1111_0110;
  localparam ctl_t CTL_MS  = 8'b0000_0011;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stage-register controls exchanged between the datapath and the scheduler.
interface pipeline_ctrl_if
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic               start_i;
  logic               hz_load_use_i;
  logic               br_taken_i;
  logic               mem_req_i;
  logic               mem_ack_i;
  logic               pc_we_o;
  logic               ifid_en_o;
  logic               ifid_flush_o;
  logic               idex_en_o;
  logic               idex_flush_o;
  logic               exmem_en_o;
  logic               memwb_en_o;
  logic               memwb_bubble_o;
  logic [STATE_W-1:0] state_o;
  logic               err_o;
  logic [CNT_W-1:0]   stall_cnt_o;

  modport slave (
    input  start_i, hz_load_use_i, br_taken_i, mem_req_i, mem_ack_i,
    output pc_we_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o,
           exmem_en_o, memwb_en_o, memwb_bubble_o, state_o, err_o, stall_cnt_o
  );

  modport master (
    output start_i, hz_load_use_i, br_taken_i, mem_req_i, mem_ack_i,
    input  pc_we_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o,
           exmem_en_o, memwb_en_o, memwb_bubble_o, state_o, err_o, stall_cnt_o
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; clear has priority and loads the inc bit so a count can restart at 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d    = '0;
      count_d[0] = inc_i;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Single owner of pipeline advance: Mealy stall/flush scheduler with memory-timeout detection.
module pipeline_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  pipeline_ctrl_if.slave  bus
);

  localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e              state_q, state_d;
  ctl_t                ctl;
  ctl_t                front;
  logic                mem_stall, mem_done;
  logic                wait_clr, wait_inc;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                stall_inc;

  assign mem_stall = bus.mem_req_i & ~bus.mem_ack_i;
  assign mem_done  = bus.mem_req_i &  bus.mem_ack_i;

  // Front-end rules shared by RUN and the MEM_WAIT completion cycle; load-use masks the branch.
  always_comb begin
    front = CTL_ALL;
    if (bus.hz_load_use_i)   front = CTL_LU;
    else if (bus.br_taken_i) front = CTL_BR;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ctl      = CTL_OFF;
    wait_clr = 1'b0;
    wait_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) state_d = RUN;
      end
      RUN: begin
        wait_clr = 1'b1;
        if (!bus.start_i) begin
          state_d = IDLE;
        end else if (mem_stall) begin
          ctl      = CTL_MS;
          wait_inc = 1'b1;
          state_d  = (MEM_TIMEOUT == 1) ? ERROR : MEM_WAIT;
        end else begin
          ctl = front;
        end
      end
      MEM_WAIT: begin
        if (mem_done) begin
          ctl     = front;
          state_d = bus.start_i ? RUN : IDLE;
        end else begin
          // wait_cnt already holds the stalled cycles before this one.
          ctl      = CTL_MS;
          wait_inc = 1'b1;
          if (wait_cnt == WAIT_LAST) state_d = ERROR;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_inc = ((state_q == RUN) || (state_q == MEM_WAIT)) && bus.start_i && !ctl.pc_we;

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .clear_i (wait_clr),
    .inc_i   (wait_inc),
    .count_o (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .clear_i (1'b0),
    .inc_i   (stall_inc),
    .count_o (bus.stall_cnt_o)
  );

  assign bus.pc_we_o        = ctl.pc_we;
  assign bus.ifid_en_o      = ctl.ifid_en;
  assign bus.ifid_flush_o   = ctl.ifid_flush;
  assign bus.idex_en_o      = ctl.idex_en;
  assign bus.idex_flush_o   = ctl.idex_flush;
  assign bus.exmem_en_o     = ctl.exmem_en;
  assign bus.memwb_en_o     = ctl.memwb_en;
  assign bus.memwb_bubble_o = ctl.memwb_bubble;
  assign bus.state_o        = state_q;
  assign bus.err_o          = (state_q == ERROR);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl with MEM_TIMEOUT=4 and CNT_W=4.
module tb_pipeline_ctrl;

  localparam logic [7:0] E_OFF = 8'b0000_0000;
  localparam logic [7:0] E_ALL = 8'b1101_0110;
  localparam logic [7:0] E_LU  = 8'b0001_1110;
  localparam logic [7:0] E_BR  = 8'b1111_0110;
  localparam logic [7:0] E_MS  = 8'b0000_0011;

  typedef struct {
    logic [7:0] ctl;
    logic [1:0] st;
    logic       err;
    logic [3:0] cnt;
    string      tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  exp_t sb[$];

  pipeline_ctrl_if #(.CNT_W(4)) bus ();

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic st, input logic lu, input logic br, input logic rq, input logic ak,
                      input logic [7:0] ectl, input logic [1:0] est, input logic eerr,
                      input logic [3:0] ecnt, input string tag);
    exp_t e;
    bus.start_i       = st;
    bus.hz_load_use_i = lu;
    bus.br_taken_i    = br;
    bus.mem_req_i     = rq;
    bus.mem_ack_i     = ak;
    sb.push_back('{ctl: ectl, st: est, err: eerr, cnt: ecnt, tag: tag});
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, ".ctl"}, 32'({bus.pc_we_o, bus.ifid_en_o, bus.ifid_flush_o, bus.idex_en_o,
                               bus.idex_flush_o, bus.exmem_en_o, bus.memwb_en_o, bus.memwb_bubble_o}),
          32'(e.ctl));
    check({e.tag, ".state"}, 32'(bus.state_o), 32'(e.st));
    check({e.tag, ".err"}, 32'(bus.err_o), 32'(e.err));
    check({e.tag, ".cnt"}, 32'(bus.stall_cnt_o), 32'(e.cnt));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    bus.start_i       = 1'b0;
    bus.hz_load_use_i = 1'b0;
    bus.br_taken_i    = 1'b0;
    bus.mem_req_i     = 1'b0;
    bus.mem_ack_i     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n             = 1'b0;
    bus.start_i       = 1'b0;
    bus.hz_load_use_i = 1'b0;
    bus.br_taken_i    = 1'b0;
    bus.mem_req_i     = 1'b0;
    bus.mem_ack_i     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.state", 32'(bus.state_o), 32'd0);
    check("rst.err", 32'(bus.err_o), 32'd0);
    check("rst.cnt", 32'(bus.stall_cnt_o), 32'd0);
    check("rst.pc_we", 32'(bus.pc_we_o), 32'd0);
    rst_n = 1'b1;

    // Start and free-run
    step(1, 0, 0, 0, 0, E_OFF, 2'd0, 0, 4'd0, "idle_start");
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, E_ALL, 2'd1, 0, 4'd0, "run");

    // Single load-use pulse
    step(1, 1, 0, 0, 0, E_LU,  2'd1, 0, 4'd0, "lu");
    step(1, 0, 0, 0, 0, E_ALL, 2'd1, 0, 4'd1, "lu_after");

    // Load-use masks a simultaneous branch, which is then re-presented
    step(1, 1, 1, 0, 0, E_LU,  2'd1, 0, 4'd1, "lu_br");
    step(1, 0, 1, 0, 0, E_BR,  2'd1, 0, 4'd2, "br");
    step(1, 0, 0, 0, 0, E_ALL, 2'd1, 0, 4'd2, "br_after");

    // Memory wait of three cycles
    do_reset();
    step(1, 0, 0, 0, 0, E_OFF, 2'd0, 0, 4'd0, "m_idle");
    step(1, 0, 0, 0, 0, E_ALL, 2'd1, 0, 4'd0, "m_run");
    step(1, 0, 0, 1, 0, E_MS,  2'd1, 0, 4'd0, "m_stall1");
    step(1, 0, 0, 1, 0, E_MS,  2'd2, 0, 4'd1, "m_stall2");
    step(1, 0, 0, 1, 0, E_MS,  2'd2, 0, 4'd2, "m_stall3");
    step(1, 0, 0, 1, 1, E_ALL, 2'd2, 0, 4'd3, "m_ack");
    step(1, 0, 0, 0, 0, E_ALL, 2'd1, 0, 4'd3, "m_resume");

    // Stop and restart
    step(0, 0, 0, 0, 0, E_OFF, 2'd1, 0, 4'd3, "stop");
    step(0, 0, 0, 0, 0, E_OFF, 2'd0, 0, 4'd3, "stopped");
    step(1, 0, 0, 0, 0, E_OFF, 2'd0, 0, 4'd3, "restart");
    step(1, 0, 0, 0, 0, E_ALL, 2'd1, 0, 4'd3, "rerun");

    // Memory timeout after four stalled cycles, then ERROR ignores start_i
    step(1, 0, 0, 1, 0, E_MS,  2'd1, 0, 4'd3, "to1");
    step(1, 0, 0, 1, 0, E_MS,  2'd2, 0, 4'd4, "to2");
    step(0, 0, 0, 1, 0, E_MS,  2'd2, 0, 4'd5, "to3");
    step(1, 0, 0, 1, 0, E_MS,  2'd2, 0, 4'd5, "to4");
    step(1, 0, 0, 1, 0, E_OFF, 2'd3, 1, 4'd6, "err1");
    step(0, 0, 0, 0, 0, E_OFF, 2'd3, 1, 4'd6, "err2");
    step(1, 0, 0, 0, 0, E_OFF, 2'd3, 1, 4'd6, "err3");

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.state", 32'(bus.state_o), 32'd0);
    check("arst.err", 32'(bus.err_o), 32'd0);
    check("arst.cnt", 32'(bus.stall_cnt_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Stall counter saturation
    step(1, 0, 0, 0, 0, E_OFF, 2'd0, 0, 4'd0, "s_idle");
    step(1, 0, 0, 0, 0, E_ALL, 2'd1, 0, 4'd0, "s_run");
    for (int i = 0; i < 20; i++)
      step(1, 1, 0, 0, 0, E_LU, 2'd1, 0, (i > 15) ? 4'd15 : 4'(i), "sat_lu");
    step(1, 0, 0, 0, 0, E_ALL, 2'd1, 0, 4'd15, "sat_hold");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
